// File: rtl/matrix_alu_seq_if.sv
// Operand/result bundle between the instruction decoder (master) and
// matrix_alu_seq (slave).
interface matrix_alu_seq_if #(
  parameter int N  = 5,
  parameter int W  = 8,
  parameter int DW = 3*W+2
);
  logic                  start;
  logic [3:0]            opcode;
  logic signed [W-1:0]   data_escalar;
  logic [N*N*W-1:0]      matrizA;
  logic [N*N*W-1:0]      matrizB;
  logic [N*N*W-1:0]      matriz_resultante;
  logic signed [DW-1:0]  det;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic                  err;

  modport master (
    output start, opcode, data_escalar, matrizA, matrizB,
    input  matriz_resultante, det, busy, done, ovf, err
  );
  modport slave (
    input  start, opcode, data_escalar, matrizA, matrizB,
    output matriz_resultante, det, busy, done, ovf, err
  );
endinterface

// File: rtl/matrix_alu_seq.sv
// Handshaked N x N signed matrix ALU: operands latched on start, multi-cycle
// ops (row-serial multiply, two-phase 3x3 determinant) sequenced by an FSM.
module matrix_alu_seq #(
  parameter int N   = 5,
  parameter int W   = 8,
  parameter int SAT = 0,
  parameter int DW  = 3*W+2
) (
  input  logic            clk,
  input  logic            rst_n,
  matrix_alu_seq_if.slave bus
);
  localparam int MW = N*N*W;
  localparam int XW = (DW > 2*W+3) ? DW : 2*W+3;
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  typedef logic signed [XW-1:0] wide_t;
  localparam wide_t MAXV = (wide_t'(1) <<< (W-1)) - wide_t'(1);
  localparam wide_t MINV = -(wide_t'(1) <<< (W-1));

  localparam logic [3:0] OP_ADD = 4'b0011, OP_SUB = 4'b0100, OP_MUL = 4'b0101,
                         OP_TRN = 4'b0110, OP_NEG = 4'b0111, OP_SCL = 4'b1000,
                         OP_DT2 = 4'b1001, OP_DT3 = 4'b1010;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [3:0]           op_q, op_d;
  logic [MW-1:0]        a_q, a_d, b_q, b_d;
  logic [MW-1:0]        wrk_q, wrk_d, res_q, res_d;
  logic signed [W-1:0]  s_q, s_d;
  logic signed [DW-1:0] det_q, det_d;
  wide_t                dacc_q, dacc_d;
  logic                 ovf_q, ovf_d, err_q, err_d;

  // Out-of-range indices read as 0 so small-N builds never slice past the bus.
  function automatic wide_t ea(input int i, input int j);
    logic signed [W-1:0] e;
    e = '0;
    if (i < N && j < N) e = a_q[(i*N+j)*W +: W];
    return wide_t'(e);
  endfunction

  function automatic wide_t eb(input int i, input int j);
    logic signed [W-1:0] e;
    e = '0;
    if (i < N && j < N) e = b_q[(i*N+j)*W +: W];
    return wide_t'(e);
  endfunction

  function automatic logic oor(input wide_t v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic [W-1:0] fit(input wide_t v);
    if (SAT != 0 && v > MAXV) return MAXV[W-1:0];
    if (SAT != 0 && v < MINV) return MINV[W-1:0];
    return v[W-1:0];
  endfunction

  always_comb begin
    wide_t v, pos, neg;
    logic  last, is_det;
    state_d = state_q;
    row_d   = row_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    wrk_d   = wrk_q;
    res_d   = res_q;
    det_d   = det_q;
    dacc_d  = dacc_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    v       = '0;
    pos     = '0;
    neg     = '0;
    last    = 1'b0;
    is_det  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        op_d    = bus.opcode;
        a_d     = bus.matrizA;
        b_d     = bus.matrizB;
        s_d     = bus.data_escalar;
        row_d   = '0;
        wrk_d   = '0;
        dacc_d  = '0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        state_d = EXEC;
      end
      EXEC: begin
        last = 1'b1;
        case (op_q)
          OP_ADD, OP_SUB, OP_NEG, OP_SCL:
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                case (op_q)
                  OP_ADD:  v = ea(i, j) + eb(i, j);
                  OP_SUB:  v = ea(i, j) - eb(i, j);
                  OP_NEG:  v = -ea(i, j);
                  default: v = wide_t'(s_q) * ea(i, j);
                endcase
                wrk_d[(i*N+j)*W +: W] = fit(v);
                ovf_d = ovf_d | oor(v);
              end
            end
          OP_TRN:
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++)
                wrk_d[(i*N+j)*W +: W] = a_q[(j*N+i)*W +: W];
          OP_MUL: begin
            // One output row per cycle; rows land in wrk_q, hidden until done.
            for (int j = 0; j < N; j++) begin
              v = '0;
              for (int k = 0; k < N; k++) v = v + ea(int'(row_q), k) * eb(k, j);
              wrk_d[(int'(row_q)*N+j)*W +: W] = fit(v);
              ovf_d = ovf_d | oor(v);
            end
            last = (int'(row_q) == N-1);
            if (!last) row_d = row_q + RW'(1);
          end
          OP_DT2:
            if (N >= 2) begin
              is_det = 1'b1;
              v = ea(0, 0) * ea(1, 1) - ea(0, 1) * ea(1, 0);
            end else begin
              err_d = 1'b1;
            end
          OP_DT3:
            if (N < 3) begin
              err_d = 1'b1;
            end else if (row_q == '0) begin
              pos = ea(0, 0) * ea(1, 1) * ea(2, 2) + ea(0, 1) * ea(1, 2) * ea(2, 0)
                  + ea(0, 2) * ea(1, 0) * ea(2, 1);
              dacc_d = pos;
              row_d  = RW'(1);
              last   = 1'b0;
            end else begin
              neg = ea(0, 2) * ea(1, 1) * ea(2, 0) + ea(0, 0) * ea(1, 2) * ea(2, 1)
                  + ea(0, 1) * ea(1, 0) * ea(2, 2);
              is_det = 1'b1;
              v = dacc_q - neg;
            end
          default: err_d = 1'b1;
        endcase
        if (err_d) wrk_d = '0;
        if (is_det) begin
          wrk_d          = '0;
          wrk_d[W-1:0]   = fit(v);
          ovf_d          = ovf_d | oor(v);
        end
        if (last) begin
          res_d   = wrk_d;
          det_d   = is_det ? v[DW-1:0] : '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      wrk_q   <= '0;
      res_q   <= '0;
      det_q   <= '0;
      dacc_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      wrk_q   <= wrk_d;
      res_q   <= res_d;
      det_q   <= det_d;
      dacc_q  <= dacc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign bus.matriz_resultante = res_q;
  assign bus.det               = det_q;
  assign bus.busy              = (state_q != IDLE);
  assign bus.done              = (state_q == DONE);
  assign bus.ovf               = ovf_q;
  assign bus.err               = err_q;
endmodule

// File: tb/tb_matrix_alu_seq.sv
// Randomized bench for matrix_alu_seq: a wrapping and a saturating instance
// share stimulus and are checked against a plain-arithmetic matrix model.
module tb_matrix_alu_seq;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int DW = 3*W+2;
  localparam int MW = N*N*W;

  typedef int mat_t [N][N];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  matrix_alu_seq_if #(.N(N), .W(W), .DW(DW)) b0 ();
  matrix_alu_seq_if #(.N(N), .W(W), .DW(DW)) b1 ();

  assign b1.start        = b0.start;
  assign b1.opcode       = b0.opcode;
  assign b1.data_escalar = b0.data_escalar;
  assign b1.matrizA      = b0.matrizA;
  assign b1.matrizB      = b0.matrizB;

  matrix_alu_seq #(.N(N), .W(W), .SAT(0), .DW(DW)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  matrix_alu_seq #(.N(N), .W(W), .SAT(1), .DW(DW)) u_sat  (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference rules: exact signed arithmetic, then wrap or clamp to W bits.
  function automatic longint cvt(input longint v, input bit sat);
    longint lo, hi, span;
    lo = -(longint'(1) <<< (W-1));
    hi = -lo - 1;
    span = longint'(1) <<< W;
    if (sat) return (v > hi) ? hi : ((v < lo) ? lo : v);
    return ((v - lo) % span + span) % span + lo;
  endfunction

  function automatic bit oor(input longint v);
    return (v > (longint'(1) <<< (W-1)) - 1) || (v < -(longint'(1) <<< (W-1)));
  endfunction

  task automatic model(input logic [3:0] op, input int s, input mat_t a, input mat_t b,
                       input bit sat, output mat_t c, output longint d, output bit ov,
                       output bit er, output int lat);
    longint x [N][N];
    bit isd;
    d = 0; ov = 0; er = 0; lat = 2; isd = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c[i][j] = 0;
        x[i][j] = 0;
      end
    case (op)
      4'd3: foreach (x[i, j]) x[i][j] = longint'(a[i][j]) + b[i][j];
      4'd4: foreach (x[i, j]) x[i][j] = longint'(a[i][j]) - b[i][j];
      4'd5: begin
        lat = N + 1;
        foreach (x[i, j]) for (int k = 0; k < N; k++) x[i][j] += longint'(a[i][k]) * b[k][j];
      end
      4'd6: foreach (x[i, j]) x[i][j] = a[j][i];
      4'd7: foreach (x[i, j]) x[i][j] = -longint'(a[i][j]);
      4'd8: foreach (x[i, j]) x[i][j] = longint'(s) * a[i][j];
      4'd9: begin
        isd = 1;
        d = longint'(a[0][0]) * a[1][1] - longint'(a[0][1]) * a[1][0];
      end
      4'd10: if (N >= 3) begin
        isd = 1;
        lat = 3;
        d = longint'(a[0][0]) * (a[1][1] * a[2][2] - a[1][2] * a[2][1])
          - longint'(a[0][1]) * (a[1][0] * a[2][2] - a[1][2] * a[2][0])
          + longint'(a[0][2]) * (a[1][0] * a[2][1] - a[1][1] * a[2][0]);
      end else er = 1;
      default: er = 1;
    endcase
    if (isd) begin
      c[0][0] = int'(cvt(d, sat));
      ov = oor(d);
    end else if (!er) begin
      foreach (x[i, j]) begin
        c[i][j] = int'(cvt(x[i][j], sat));
        if (oor(x[i][j])) ov = 1;
      end
    end
  endtask

  function automatic logic [MW-1:0] pk(input mat_t m);
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[(i*N+j)*W +: W] = m[i][j][W-1:0];
    return r;
  endfunction

  function automatic int el(input logic [MW-1:0] v, input int i, input int j);
    logic signed [W-1:0] e;
    e = v[(i*N+j)*W +: W];
    return int'(e);
  endfunction

  task automatic rnd(output mat_t m);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Issue one op; poke = handshake cycle (counted from accept) on which a
  // stray start is pulsed, 0 for none.
  task automatic run(input string tag, input logic [3:0] op, input int s,
                     input mat_t a, input mat_t b, input int poke);
    mat_t   c0, c1;
    longint d0, d1;
    bit     o0, o1, e0, e1, seen;
    int     lat, lat1, n, nbusy, ndone;
    model(op, s, a, b, 1'b0, c0, d0, o0, e0, lat);
    model(op, s, a, b, 1'b1, c1, d1, o1, e1, lat1);
    @(negedge clk);
    b0.start = 1'b1; b0.opcode = op; b0.data_escalar = s[W-1:0];
    b0.matrizA = pk(a); b0.matrizB = pk(b);
    @(negedge clk);
    b0.start = 1'b0;
    b0.matrizA = ~b0.matrizA;
    b0.matrizB = ~b0.matrizB;
    n = 1; nbusy = int'(b0.busy); seen = b0.done;
    while (!seen && n < 40) begin
      b0.start = (n == poke);
      b0.opcode = 4'b0011;
      @(negedge clk);
      n++;
      nbusy += int'(b0.busy);
      seen = b0.done;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy"}, nbusy, lat);
    chk({tag, "_ovf"}, b0.ovf, o0);
    chk({tag, "_ovf_sat"}, b1.ovf, o1);
    chk({tag, "_err"}, b0.err, e0);
    chk({tag, "_err_sat"}, b1.err, e1);
    chk({tag, "_det"}, longint'(b0.det), e0 ? 0 : d0);
    chk({tag, "_det_sat"}, longint'(b1.det), e1 ? 0 : d1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        chk($sformatf("%s_c%0d%0d", tag, i, j), el(b0.matriz_resultante, i, j), c0[i][j]);
        chk($sformatf("%s_sc%0d%0d", tag, i, j), el(b1.matriz_resultante, i, j), c1[i][j]);
      end
    b0.start = (poke == n);
    @(negedge clk);
    b0.start = 1'b0;
    chk({tag, "_pulse"}, b0.done, 0);
    chk({tag, "_idle"}, b0.busy, 0);
    ndone = 0;
    repeat (N + 2) begin
      @(negedge clk);
      ndone += int'(b0.done);
    end
    chk({tag, "_extra_done"}, ndone, 0);
    chk({tag, "_hold"}, el(b0.matriz_resultante, N-1, N-1), c0[N-1][N-1]);
  endtask

  initial begin
    mat_t a, b, z;
    b0.start = 1'b0; b0.opcode = '0; b0.data_escalar = '0;
    b0.matrizA = '0; b0.matrizB = '0;
    foreach (z[i, j]) z[i][j] = 0;
    #1;
    chk("rst_busy", b0.busy, 0);
    chk("rst_done", b0.done, 0);
    chk("rst_res", b0.matriz_resultante == '0, 1);
    chk("rst_det", b0.det, 0);
    chk("rst_flags", {b0.ovf, b0.err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (a[i, j]) begin a[i][j] = 100; b[i][j] = 50; end
    run("add_ovf", 4'b0011, 0, a, b, 0);

    foreach (a[i, j]) begin a[i][j] = (i == j); b[i][j] = i*5 + j; end
    run("mul_id", 4'b0101, 0, a, b, 2);
    foreach (a[i, j]) begin a[i][j] = 2; b[i][j] = 2; end
    run("mul_2", 4'b0101, 0, a, b, 0);

    foreach (a[i, j]) a[i][j] = 3;
    a[0][0] = -128;
    foreach (b[i, j]) b[i][j] = 0;
    run("neg_min", 4'b0111, 0, a, b, 0);
    a[1][3] = 77; a[4][0] = -9;
    run("trn", 4'b0110, 0, a, b, 0);

    a = z;
    a[0][0] = 2; a[0][1] = 0; a[0][2] = 1;
    a[1][0] = 1; a[1][1] = 3; a[1][2] = 2;
    a[2][0] = 1; a[2][1] = 1; a[2][2] = 1;
    a[3][3] = 99;
    run("det3", 4'b1010, 0, a, b, 0);
    a[0][0] = 10; a[0][1] = 20; a[1][0] = 30; a[1][1] = 40;
    run("det2", 4'b1001, 0, a, b, 0);

    rnd(a); rnd(b);
    run("bad_op", 4'b1011, 0, a, b, 2);
    run("scl", 4'b1000, -3, a, b, 0);

    // Abort a multiply mid-way with reset.
    @(negedge clk);
    b0.start = 1'b1; b0.opcode = 4'b0101; b0.matrizA = pk(a); b0.matrizB = pk(b);
    @(negedge clk);
    b0.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", b0.busy, 0);
    chk("abort_done", b0.done, 0);
    chk("abort_res", b0.matriz_resultante == '0, 1);
    chk("abort_det", b0.det, 0);
    chk("abort_flags", {b0.ovf, b0.err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 2) @(negedge clk);
    chk("abort_no_done", b0.done | b0.busy, 0);
    run("add_post_rst", 4'b0011, 0, a, b, 0);

    for (int t = 0; t < 40; t++) begin
      logic [3:0] op;
      int s;
      op = 4'($urandom_range(0, 15));
      s = int'($urandom_range(0, 255)) - 128;
      rnd(a); rnd(b);
      if (t % 4 == 0) foreach (a[i, j]) a[i][j] = a[i][j] / 16;
      run($sformatf("rnd%0d_op%0d", t, op), op, s, a, b, (t % 3 == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
